// File: rtl/pwm_multi_channel_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : values of the mode input and of the latched mode
//   dir_e                   : counter direction (also the counter FSM state)
//   ch_w()                  : width of the channel-select field, never below 1
package pwm_multi_channel_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int ch_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle of the PWM generator.
//   i_enable      run (1) / stop and idle (0)
//   i_mode        0 = edge-aligned, 1 = center-aligned
//   i_period      terminal count, taken at period boundaries
//   i_wr_en       single-cycle duty write strobe
//   i_wr_ch       channel addressed by the write
//   i_wr_data     new compare value
//   i_invert      per-channel polarity (1 = active-low)
//   o_pwm_out     registered PWM outputs
//   o_period_tick one-cycle pulse after each period boundary
// master = CPU/register side, slave = PWM generator.
interface pwm_multi_channel_if
  import pwm_multi_channel_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W = ch_w(CHANNELS);

  logic                i_enable;
  logic                i_mode;
  logic [WIDTH-1:0]    i_period;
  logic                i_wr_en;
  logic [CH_W-1:0]     i_wr_ch;
  logic [WIDTH-1:0]    i_wr_data;
  logic [CHANNELS-1:0] i_invert;
  logic [CHANNELS-1:0] o_pwm_out;
  logic                o_period_tick;

  modport master (
    output i_enable, i_mode, i_period, i_wr_en, i_wr_ch, i_wr_data, i_invert,
    input  o_pwm_out, o_period_tick
  );

  modport slave (
    input  i_enable, i_mode, i_period, i_wr_en, i_wr_ch, i_wr_data, i_invert,
    output o_pwm_out, o_period_tick
  );

endinterface

// File: rtl/pwm_multi_channel_cmp.sv
// One PWM channel: shadow compare register, active compare register that is
// reloaded at period boundaries (and continuously while stopped), compare,
// polarity and output flop.
//   clk, reset_n  clock, asynchronous active-low reset
//   i_enable      generator running
//   i_boundary    current cycle is a period boundary
//   i_wr_sel      a duty write targets this channel in this cycle
//   i_wr_data     value of that write
//   i_cnt         shared period counter
//   i_invert      output polarity
//   o_pwm         registered output
module pwm_multi_channel_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_boundary,
  input  logic             i_wr_sel,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_invert,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_pwm;
  logic [WIDTH-1:0] w_shadow_next;
  logic             w_raw;

  // A write landing in the boundary cycle is forwarded straight into the
  // active register, so it takes effect for the period that is starting.
  assign w_shadow_next = i_wr_sel ? i_wr_data : r_shadow;
  assign w_raw         = (i_cnt < r_active);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_next;
      if (!i_enable || i_boundary) begin
        r_active <= w_shadow_next;
      end
      r_pwm <= i_enable ? (w_raw ^ i_invert) : i_invert;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter (edge- or
// center-aligned) feeds CHANNELS compare channels with double-buffered duty.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      control/status bundle (slave side), see pwm_multi_channel_if
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  pwm_multi_channel_if.slave  bus
);

  localparam int CH_W = ch_w(CHANNELS);

  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    w_cnt_next;
  logic [WIDTH-1:0]    r_period_act;
  logic [WIDTH-1:0]    w_period_next;
  logic                r_mode_act;
  logic                w_mode_next;
  logic                r_tick;
  logic                w_boundary;
  dir_e                r_dir;
  dir_e                w_dir_next;
  logic [CHANNELS-1:0] w_wr_sel;
  logic [CHANNELS-1:0] w_pwm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_dir        <= DIR_UP;
      r_period_act <= '0;
      r_mode_act   <= MODE_EDGE;
      r_tick       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_dir        <= w_dir_next;
      r_period_act <= w_period_next;
      r_mode_act   <= w_mode_next;
      r_tick       <= w_boundary;
    end
  end

  always_comb begin
    w_boundary    = 1'b0;
    w_cnt_next    = r_cnt;
    w_dir_next    = r_dir;
    w_period_next = r_period_act;
    w_mode_next   = r_mode_act;

    if (bus.i_enable) begin
      if (r_period_act == '0) begin
        w_boundary = 1'b1;
      end else if (r_mode_act == MODE_EDGE) begin
        w_boundary = (r_cnt == r_period_act);
      end else begin
        w_boundary = (r_cnt == '0) && (r_dir == DIR_DOWN);
      end
    end

    if (!bus.i_enable) begin
      w_cnt_next    = '0;
      w_dir_next    = DIR_UP;
      w_period_next = bus.i_period;
      w_mode_next   = bus.i_mode;
    end else if (w_boundary) begin
      w_period_next = bus.i_period;
      w_mode_next   = bus.i_mode;
      w_dir_next    = DIR_UP;
      // An edge period ends at the top and restarts at 0. A center period
      // ends on its 0, which must not repeat, so the next one starts at 1.
      if (r_mode_act == MODE_EDGE) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = (bus.i_period != '0) ? WIDTH'(1) : '0;
      end
    end else begin
      case (r_dir)
        DIR_UP: begin
          if ((r_mode_act == MODE_CENTER) && (r_cnt == r_period_act)) begin
            w_dir_next = DIR_DOWN;
            w_cnt_next = r_cnt - WIDTH'(1);
          end else begin
            w_cnt_next = r_cnt + WIDTH'(1);
          end
        end
        DIR_DOWN: w_cnt_next = r_cnt - WIDTH'(1);
        default:  w_cnt_next = '0;
      endcase
    end
  end

  // Out-of-range channel indices match no decoder and are dropped.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_wr_sel[gi] = bus.i_wr_en && (bus.i_wr_ch == CH_W'(gi));

    pwm_multi_channel_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_enable   (bus.i_enable),
      .i_boundary (w_boundary),
      .i_wr_sel   (w_wr_sel[gi]),
      .i_wr_data  (bus.i_wr_data),
      .i_cnt      (r_cnt),
      .i_invert   (bus.i_invert[gi]),
      .o_pwm      (w_pwm[gi])
    );
  end

  assign bus.o_pwm_out     = w_pwm;
  assign bus.o_period_tick = r_tick;

endmodule
